player_step_ctrl: RTL and testbench

Sequencing controller between the one-hot button inputs and the bank of rectangle collision blocks. It owns the player position, waits for the rectangles' registered block flags to settle after each move, and arbitrates one direction at a time. It applies a single-pixel step only when no rectangle blocks that direction, and auto-repeats while the button is held. Its outputs `player_hPos`/`player_vPos` feed every rectangle instance and the renderer.

---
 rtl/player_step_ctrl_if.sv | 25 ++
 rtl/player_step_ctrl.sv | 147 ++++++++++++++
 tb/tb_player_step_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/player_step_ctrl_if.sv
// rtl/player_step_ctrl_if.sv - button, block-flag and player-position bundle for player_step_ctrl
interface player_step_ctrl_if #(
  parameter int NRECT = 8
);
  logic [3:0]       btns;
  logic [NRECT-1:0] up_block;
  logic [NRECT-1:0] down_block;
  logic [NRECT-1:0] left_block;
  logic [NRECT-1:0] right_block;
  logic [9:0]       player_hPos;
  logic [9:0]       player_vPos;
  logic             moving;
  logic             blocked;
  logic [15:0]      step_count;

  modport master (
    output btns, up_block, down_block, left_block, right_block,
    input  player_hPos, player_vPos, moving, blocked, step_count
  );

  modport slave (
    input  btns, up_block, down_block, left_block, right_block,
    output player_hPos, player_vPos, moving, blocked, step_count
  );
endinterface

// File: rtl/player_step_ctrl.sv
// rtl/player_step_ctrl.sv - one-direction-at-a-time player stepper with settle, collision check and auto-repeat
module player_step_ctrl #(
  parameter int NRECT   = 8,
  parameter int PWIDTH  = 12,
  parameter int PHEIGHT = 12,
  parameter int HMAX    = 640,
  parameter int VMAX    = 480,
  parameter int SETTLE  = 2,
  parameter int REPEAT  = 16,
  parameter int H_INIT  = 0,
  parameter int V_INIT  = 0
) (
  input  logic                btnClk,
  input  logic                rst,
  player_step_ctrl_if.slave   bus
);

  localparam int CMAX = (SETTLE > REPEAT) ? SETTLE : REPEAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
  localparam logic [CW-1:0] REPEAT_LD = CW'(REPEAT - 1);
  localparam logic [9:0]    H_LAST    = 10'(HMAX - PWIDTH);
  localparam logic [9:0]    V_LAST    = 10'(VMAX - PHEIGHT);
  localparam logic [9:0]    H_RST     = 10'(H_INIT);
  localparam logic [9:0]    V_RST     = 10'(V_INIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MOVE,
    S_HOLD
  } state_t;

  state_t        r_state;
  logic [3:0]    r_dir;
  logic [CW-1:0] r_cnt;
  logic [9:0]    r_h_pos;
  logic [9:0]    r_v_pos;
  logic          r_moving;
  logic          r_blocked;
  logic [15:0]   r_step_count;

  logic       w_btn_onehot;
  logic       w_dir_blocked;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;

  assign w_btn_onehot = (bus.btns == 4'd8) || (bus.btns == 4'd4) ||
                        (bus.btns == 4'd2) || (bus.btns == 4'd1);

  always_comb begin
    w_dir_blocked = 1'b0;
    case (r_dir)
      4'd8:    w_dir_blocked = |bus.up_block;
      4'd4:    w_dir_blocked = |bus.down_block;
      4'd2:    w_dir_blocked = |bus.right_block;
      4'd1:    w_dir_blocked = |bus.left_block;
      default: w_dir_blocked = 1'b0;
    endcase
  end

  // Edges of the playfield wrap to the opposite side.
  always_comb begin
    w_h_next = r_h_pos;
    w_v_next = r_v_pos;
    case (r_dir)
      4'd8:    w_v_next = (r_v_pos == 10'd0)   ? V_LAST : r_v_pos - 10'd1;
      4'd4:    w_v_next = (r_v_pos == V_LAST)  ? 10'd0  : r_v_pos + 10'd1;
      4'd2:    w_h_next = (r_h_pos == H_LAST)  ? 10'd0  : r_h_pos + 10'd1;
      4'd1:    w_h_next = (r_h_pos == 10'd0)   ? H_LAST : r_h_pos - 10'd1;
      default: begin
        w_h_next = r_h_pos;
        w_v_next = r_v_pos;
      end
    endcase
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_dir        <= 4'd0;
      r_cnt        <= '0;
      r_h_pos      <= H_RST;
      r_v_pos      <= V_RST;
      r_moving     <= 1'b0;
      r_blocked    <= 1'b0;
      r_step_count <= 16'd0;
    end else begin
      r_blocked <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_btn_onehot) begin
            r_dir    <= bus.btns;
            r_cnt    <= SETTLE_LD;
            r_state  <= S_SETTLE;
            r_moving <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (bus.btns != r_dir) begin
            r_state  <= S_IDLE;
            r_moving <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= S_MOVE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        // Block flags are only trusted here, after the settle window.
        S_MOVE: begin
          if (w_dir_blocked) begin
            r_blocked <= 1'b1;
          end else begin
            r_h_pos      <= w_h_next;
            r_v_pos      <= w_v_next;
            r_step_count <= r_step_count + 16'd1;
          end
          r_cnt   <= REPEAT_LD;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.btns != r_dir) begin
            r_state  <= S_IDLE;
            r_moving <= 1'b0;
          end else if (r_cnt == '0) begin
            r_cnt   <= SETTLE_LD;
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.player_hPos = r_h_pos;
  assign bus.player_vPos = r_v_pos;
  assign bus.moving      = r_moving;
  assign bus.blocked     = r_blocked;
  assign bus.step_count  = r_step_count;

endmodule

// File: tb/tb_player_step_ctrl.sv
// tb/tb_player_step_ctrl.sv - directed checks of player_step_ctrl stepping, wrap, blocking and repeat timing
module tb_player_step_ctrl;

  logic btnClk;
  logic rst;
  int   checks;
  int   errors;

  player_step_ctrl_if #(.NRECT(8)) bus ();

  player_step_ctrl #(
    .NRECT(8), .PWIDTH(12), .PHEIGHT(12), .HMAX(640), .VMAX(480),
    .SETTLE(2), .REPEAT(16), .H_INIT(100), .V_INIT(200)
  ) dut (
    .btnClk(btnClk),
    .rst   (rst),
    .bus   (bus)
  );

  initial btnClk = 1'b0;
  always #5 btnClk = ~btnClk;

  task automatic tick(input int n);
    repeat (n) @(posedge btnClk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.btns = 4'd0;
    bus.up_block = '0;
    bus.down_block = '0;
    bus.left_block = '0;
    bus.right_block = '0;
    tick(3);
    chk("rst_hpos", bus.player_hPos, 100);
    chk("rst_vpos", bus.player_vPos, 200);
    chk("rst_moving", bus.moving, 0);
    chk("rst_steps", bus.step_count, 0);
    chk("rst_blocked", bus.blocked, 0);
    rst = 1'b0;
    tick(1);

    // reset asserted mid-SETTLE
    bus.btns = 4'd1;
    tick(2);
    chk("settle_moving", bus.moving, 1);
    rst = 1'b1;
    #1;
    chk("midrst_moving", bus.moving, 0);
    tick(4);
    chk("midrst_hpos", bus.player_hPos, 100);
    chk("midrst_steps", bus.step_count, 0);
    rst = 1'b0;
    bus.btns = 4'd0;
    tick(1);

    // held right: first step at k+3, then every 19 edges
    bus.btns = 4'd2;
    tick(3);
    chk("right_pre", bus.player_hPos, 100);
    tick(1);
    chk("right_1", bus.player_hPos, 101);
    chk("right_1_cnt", bus.step_count, 1);
    tick(18);
    chk("right_pre2", bus.player_hPos, 101);
    tick(1);
    chk("right_2", bus.player_hPos, 102);
    tick(19);
    chk("right_3", bus.player_hPos, 103);
    chk("right_3_cnt", bus.step_count, 3);
    bus.btns = 4'd0;
    tick(1);
    chk("release_idle", bus.moving, 0);

    // hold left from 103 down to 0 then wrap to 628
    bus.btns = 4'd1;
    tick(4);
    chk("left_1", bus.player_hPos, 102);
    for (int i = 0; i < 102; i++) tick(19);
    chk("left_zero", bus.player_hPos, 0);
    tick(19);
    chk("left_wrap", bus.player_hPos, 628);
    chk("left_cnt", bus.step_count, 107);
    bus.btns = 4'd0;
    tick(1);

    bus.btns = 4'd2;
    tick(4);
    chk("right_wrap", bus.player_hPos, 0);
    chk("right_wrap_cnt", bus.step_count, 108);
    bus.btns = 4'd0;
    tick(1);

    // hold up from 200 down to 0 then wrap to 468
    bus.btns = 4'd8;
    tick(4);
    chk("up_1", bus.player_vPos, 199);
    for (int i = 0; i < 199; i++) tick(19);
    chk("up_zero", bus.player_vPos, 0);
    tick(19);
    chk("up_wrap", bus.player_vPos, 468);
    chk("up_cnt", bus.step_count, 309);
    bus.btns = 4'd0;
    tick(1);

    // down refused by rectangle 3, then accepted (and wraps) on repeat
    bus.btns = 4'd4;
    bus.down_block = 8'h08;
    tick(3);
    chk("blk_pre", bus.blocked, 0);
    tick(1);
    chk("blk_pulse", bus.blocked, 1);
    chk("blk_vpos", bus.player_vPos, 468);
    chk("blk_cnt", bus.step_count, 309);
    bus.down_block = 8'h00;
    tick(1);
    chk("blk_drop", bus.blocked, 0);
    tick(18);
    chk("down_wrap", bus.player_vPos, 0);
    chk("down_wrap_cnt", bus.step_count, 310);

    // flags high only while in HOLD are ignored
    bus.down_block = 8'hFF;
    tick(10);
    bus.down_block = 8'h00;
    tick(9);
    chk("hold_flag_vpos", bus.player_vPos, 1);
    chk("hold_flag_blk", bus.blocked, 0);
    chk("hold_flag_cnt", bus.step_count, 311);
    bus.btns = 4'd0;
    tick(1);

    // release during SETTLE
    bus.btns = 4'd2;
    tick(2);
    chk("rel_settle_mv", bus.moving, 1);
    bus.btns = 4'd0;
    tick(5);
    chk("rel_settle_h", bus.player_hPos, 0);
    chk("rel_settle_mv2", bus.moving, 0);
    chk("rel_settle_cnt", bus.step_count, 311);

    // multi-hot ignored
    bus.btns = 4'd12;
    tick(5);
    chk("multi_moving", bus.moving, 0);
    chk("multi_vpos", bus.player_vPos, 1);
    bus.btns = 4'd0;
    tick(1);

    // up then switch to down while in HOLD
    bus.btns = 4'd8;
    tick(4);
    chk("sw_up", bus.player_vPos, 0);
    tick(5);
    bus.btns = 4'd4;
    tick(1);
    chk("sw_idle", bus.moving, 0);
    tick(3);
    chk("sw_pre", bus.player_vPos, 0);
    tick(1);
    chk("sw_down", bus.player_vPos, 1);
    chk("sw_cnt", bus.step_count, 313);
    bus.btns = 4'd0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
